// File: rtl/dot_accum_seq_if.sv
// rtl/dot_accum_seq_if.sv - product-in / result-out handshake bundle for dot_accum_seq
//
// Purpose : groups the beat input stream and the result output stream.
// Signals : in_valid/in_data/in_ready   - one signed Q1.1.14 product per beat
//           out_valid/out_ready         - result handshake
//           out_data/out_sat            - saturated Q1.1.14 result and clamp flag
// Modports: slave  - the accumulator (consumes beats, produces results)
//           master - the surrounding logic (produces beats, consumes results)
interface dot_accum_seq_if;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sat
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sat
    );
endinterface

// File: rtl/dot_accum_seq.sv
// rtl/dot_accum_seq.sv - N_TERMS-beat signed dot-product accumulator with 16-bit saturating output
//
// Purpose : sums N_TERMS rescaled Q1.1.14 products in an ACC_W-bit accumulator,
//           clamps the sum to 16 bits and holds the result until it is taken.
// Macro   : DOT_ACCUM_RELU_EN - when defined, negative saturated results are
//           replaced by 0 (out_sat still reflects the clamp before ReLU).
// Ports   : clk        - clock, all state on rising edge
//           rst        - asynchronous active-high reset
//           i_clr      - synchronous abort, discards the partial sum
//           bus        - dot_accum_seq_if.slave (beat input, result output)
//           o_term_cnt - beats accepted for the current result
module dot_accum_seq #(
    parameter int N_TERMS = 784,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    dot_accum_seq_if.slave   bus,
    output logic [CNT_W-1:0] o_term_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [CNT_W-1:0]   r_cnt;
    logic                      r_out_valid;
    logic signed [15:0]        r_out_data;
    logic                      r_out_sat;

    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic        [CNT_W-1:0]   w_cnt_nxt;
    logic                      w_valid_nxt;
    logic signed [15:0]        w_data_nxt;
    logic                      w_sat_nxt;

    logic                      w_in_ready;
    logic                      w_beat;
    logic signed [ACC_W-1:0]   w_in_ext;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W-1:0]   w_sum;
    logic        [CNT_W-1:0]   w_cnt_inc;
    logic                      w_last;
    logic signed [15:0]        w_clamp;
    logic                      w_clamped;
    logic signed [15:0]        w_result;

    // in_ready depends only on state so out_ready never reaches it combinationally.
    assign w_in_ready = (r_state != S_HOLD);
    assign w_beat     = bus.in_valid && w_in_ready;
    assign w_in_ext   = {{(ACC_W-16){bus.in_data[15]}}, bus.in_data};

    // The first beat of a vector starts from zero rather than trusting r_acc.
    assign w_base     = (r_state == S_IDLE) ? '0 : r_acc;
    assign w_sum      = w_base + w_in_ext;
    assign w_cnt_inc  = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == CNT_W'(N_TERMS));

    // Narrowing to 16 bits is the only place the value can be clamped.
    always_comb begin
        w_clamp   = w_sum[15:0];
        w_clamped = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_clamp   = 16'sh7FFF;
            w_clamped = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_clamp   = 16'sh8000;
            w_clamped = 1'b1;
        end
    end

`ifdef DOT_ACCUM_RELU_EN
    assign w_result = w_clamp[15] ? 16'sd0 : w_clamp;
`else
    assign w_result = w_clamp;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        w_sat_nxt   = r_out_sat;

        // clr beats both a simultaneous beat and a simultaneous result handshake;
        // out_data is deliberately left holding the last result.
        if (i_clr) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_beat) begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_last) begin
                            w_state_nxt = S_HOLD;
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = w_result;
                            w_sat_nxt   = w_clamped;
                        end else begin
                            w_state_nxt = S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_out_valid && bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_sat   <= w_sat_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign o_term_cnt    = r_cnt;

endmodule

// File: tb/tb_dot_accum_seq.sv
// tb/tb_dot_accum_seq.sv - scoreboard bench for dot_accum_seq with N_TERMS = 4
module tb_dot_accum_seq;

    localparam int N_TERMS = 4;
    localparam int ACC_W   = 32;
    localparam int CNT_W   = 10;

    typedef struct {
        int data;
        int sat;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             clr;
    logic [CNT_W-1:0] term_cnt;

    dot_accum_seq_if u_if ();

    dot_accum_seq #(
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr),
        .bus        (u_if),
        .o_term_cnt (term_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_sum  = 0;
    int   m_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: exact integer sum, clamp to 16 bits, optional ReLU afterwards.
    task automatic push_expected(input int sum);
        exp_t e;
        int   c;
        c = sum;
        e.sat = 0;
        if (c > 32767) begin
            c = 32767;
            e.sat = 1;
        end else if (c < -32768) begin
            c = -32768;
            e.sat = 1;
        end
`ifdef DOT_ACCUM_RELU_EN
        if (c < 0) c = 0;
`endif
        e.data = c;
        exp_q.push_back(e);
    endtask

    // Presents one beat for one cycle; bench only calls this while in_ready is expected high.
    task automatic send_beat(input int d);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 16'(d);
        m_sum += d;
        m_cnt++;
        if (m_cnt == N_TERMS) begin
            push_expected(m_sum);
            m_sum = 0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Results are compared at the falling edge, where out_ready is the value
    // that the next rising edge will see for the handshake.
    always @(negedge clk) begin
        if (!rst && u_if.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else if (u_if.out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_data", int'(u_if.out_data), e.data);
                check("res_sat", int'(u_if.out_sat), e.sat);
            end
        end
    end

    initial begin
        int exp_bp;
        rst           = 1'b1;
        clr           = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        u_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        check("rst_out_valid", int'(u_if.out_valid), 0);
        check("rst_out_data", int'(u_if.out_data), 0);
        check("rst_out_sat", int'(u_if.out_sat), 0);
        check("rst_term_cnt", int'(term_cnt), 0);
        check("rst_in_ready", int'(u_if.in_ready), 1);

        // Basic sum with single-cycle result pulse.
        send_beat(100);
        send_beat(200);
        send_beat(-50);
        send_beat(25);
        check("basic_valid_rise", int'(u_if.out_valid), 1);
        check("basic_hold_ready", int'(u_if.in_ready), 0);
        idle_cycle();
        check("basic_valid_fall", int'(u_if.out_valid), 0);
        check("basic_in_ready", int'(u_if.in_ready), 1);

        // Saturation both ways.
        for (int i = 0; i < N_TERMS; i++) send_beat(20000);
        idle_cycle();
        for (int i = 0; i < N_TERMS; i++) send_beat(-20000);
        idle_cycle();

        // Backpressure: result held, beats ignored while holding.
        u_if.out_ready = 1'b0;
        send_beat(5);
        send_beat(6);
        send_beat(7);
        send_beat(8);
        exp_bp = 26;
        for (int i = 0; i < 5; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = 16'sd7;
            check("bp_in_ready", int'(u_if.in_ready), 0);
            check("bp_out_valid", int'(u_if.out_valid), 1);
            check("bp_out_data", int'(u_if.out_data), exp_bp);
            idle_cycle();
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        idle_cycle();
        check("bp_released", int'(u_if.out_valid), 0);
        send_beat(1);
        send_beat(2);
        send_beat(3);
        send_beat(4);
        idle_cycle();

        // Gaps between beats.
        send_beat(1000);
        check("gap_cnt0", int'(term_cnt), 1);
        idle_cycle();
        check("gap_cnt1", int'(term_cnt), 1);
        idle_cycle();
        check("gap_cnt2", int'(term_cnt), 1);
        send_beat(1000);
        check("gap_cnt3", int'(term_cnt), 2);
        idle_cycle();
        check("gap_cnt4", int'(term_cnt), 2);
        send_beat(1000);
        check("gap_cnt5", int'(term_cnt), 3);
        send_beat(1000);
        idle_cycle();

        // clr together with the second beat discards the vector.
        send_beat(500);
        u_if.in_valid = 1'b1;
        u_if.in_data  = 16'sd500;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        u_if.in_valid = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        check("clr_term_cnt", int'(term_cnt), 0);
        check("clr_out_valid", int'(u_if.out_valid), 0);
        idle_cycle();
        check("clr_no_valid", int'(u_if.out_valid), 0);
        send_beat(10);
        send_beat(20);
        send_beat(30);
        send_beat(40);
        idle_cycle();

        // Asynchronous reset in the middle of a vector.
        send_beat(500);
        send_beat(500);
        #2;
        rst = 1'b1;
        #1;
        m_sum = 0;
        m_cnt = 0;
        check("arst_out_valid", int'(u_if.out_valid), 0);
        check("arst_out_data", int'(u_if.out_data), 0);
        check("arst_out_sat", int'(u_if.out_sat), 0);
        check("arst_term_cnt", int'(term_cnt), 0);
        #2;
        rst = 1'b0;
        idle_cycle();
        check("arst_in_ready", int'(u_if.in_ready), 1);
        send_beat(-1);
        send_beat(-2);
        send_beat(-3);
        send_beat(-4);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycle();
        check("drain_empty", exp_q.size(), 0);
        repeat (2) idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_accum_seq.md
# dot_accum_seq

Downstream accumulator for the 16-bit Q1.1.14 PE multiplier stage. It takes one already-rescaled signed product per beat and sums N_TERMS products (one 784-long row/column dot product) in a wide accumulator. It then saturates the sum back to 16-bit Q1.1.14 and presents the neuron result on a valid/ready output. It sits between the multiplier's `dot_out`/`finish` output and the layer result buffer.

## Interface
- N_TERMS, 784, number of products summed per result (≥1)
- ACC_W, 32, accumulator width in bits (≥ 16 + ceil(log2(N_TERMS)))
- CNT_W, 10, term counter width (2^CNT_W > N_TERMS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous abort: discard partial sum, return to IDLE
- in_valid  in  1  product beat present
- in_data  in  16  signed Q1.1.14 product
- in_ready  out  1  block accepts a beat this cycle
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_data  out  16  signed Q1.1.14 result
- out_sat  out  1  result was clamped
- term_cnt  out  CNT_W  beats accepted for the current result

## Operation
- States: IDLE, ACCUM, HOLD.
- A beat is accepted when in_valid && in_ready. in_ready = 1 in IDLE/ACCUM, 0 in HOLD.
- In HOLD, in_valid is ignored and no state changes from it.
- IDLE + accepted beat:
  - acc <= sign-extended in_data; term_cnt <= 1.
  - Go to ACCUM, or directly finalize if N_TERMS == 1.
- ACCUM + accepted beat:
  - acc <= acc + in_data (sign-extended); term_cnt += 1.
  - On the beat that makes term_cnt == N_TERMS: finalize.
- Finalize, all in the same edge:
  - sum = acc + in_data.
  - out_data <= sum clamped to [-32768, 32767].
  - out_sat <= 1 if the clamp changed the value.
  - out_valid <= 1; state <= HOLD.
- HOLD: out_data/out_sat/out_valid are held stable while out_ready = 0.
  - On out_valid && out_ready: out_valid <= 0, acc <= 0, term_cnt <= 0, state <= IDLE.
- Arithmetic: wrap-free by construction, since the ACC_W sizing rule guarantees no accumulator overflow. The only saturation point is the final 16-bit narrowing.
- clr (any state): state <= IDLE, acc <= 0, term_cnt <= 0, out_valid <= 0, out_sat <= 0. out_data is held.
- clr has priority over a simultaneous accepted beat (beat discarded) and over a simultaneous output handshake.
- Reset values: state IDLE, acc 0, term_cnt 0, out_valid 0, out_data 0, out_sat 0. in_ready = 1 after reset.
- Reset mid-operation aborts the partial sum immediately (asynchronous). No result is emitted for the aborted vector.

## Timing
- One beat per cycle sustained in IDLE/ACCUM; no bubbles required.
- Latency: out_valid rises on the same edge that accepts beat N_TERMS, so it is visible one cycle after the final beat is presented.
- Minimum result period: N_TERMS + 1 cycles. This comes from one HOLD cycle when out_ready is already high.
- in_ready is a pure function of state (no combinational path from out_ready).
- No combinational path exists from input ports to output ports.

## Configuration
- Macro: DOT_ACCUM_RELU_EN.
- Defined: after saturation, a negative result is replaced by 0 (ReLU fused into the output stage). out_sat still reports the pre-ReLU clamp.
- Undefined: signed saturated result is output unchanged.

## Test plan
(Bench uses N_TERMS = 4.)
- Basic sum: beats 100, 200, -50, 25 back-to-back, out_ready = 1.
  - out_valid for exactly 1 cycle, one cycle after the last beat.
  - out_data = 275, out_sat = 0; in_ready back to 1 next cycle.
- Saturation high: four beats of 20000 -> out_data = 32767, out_sat = 1.
- Saturation low: four beats of -20000.
  - Without macro: out_data = -32768, out_sat = 1.
  - With DOT_ACCUM_RELU_EN: out_data = 0, out_sat = 1.
- Backpressure: complete a vector with out_ready = 0 for 5 cycles while driving in_valid = 1, in_data = 7.
  - out_data is stable and in_ready = 0 throughout; the beats are ignored.
  - After out_ready = 1, the next vector 1, 2, 3, 4 -> out_data = 10.
- Gaps: beats 1000, (2 idle cycles), 1000, (1 idle cycle), 1000, 1000.
  - out_data = 4000; term_cnt reads 1, 1, 1, 2, 2, 3 across the sequence.
- Abort/reset:
  - Assert clr together with the 2nd beat of 500, 500 -> term_cnt = 0, no out_valid.
  - Then 10, 20, 30, 40 -> 100.
  - Repeat with async rst mid-vector -> all outputs 0; the following vector sums correctly.
